// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite slave write path: response codes,
// write-FSM state encoding and the strobe-width derivation.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_WRITE  = 3'd2,
    ST_RESP   = 3'd3,
    ST_WAIT_B = 3'd4
  } wr_state_e;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/axil_hold_reg.sv
// One-entry valid/ready capture register. Ready is registered and only
// reopens when the entry is empty and the owner says new traffic is allowed.
module axil_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             valid,
  input  logic [WIDTH-1:0] din,
  input  logic             open_nxt,
  input  logic             clr,
  output logic             ready,
  output logic             full,
  output logic [WIDTH-1:0] dout
);

  logic             full_q;
  logic             ready_q;
  logic             full_nxt;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    full_nxt = full_q;
    if (clr)
      full_nxt = 1'b0;
    else if (valid && ready_q)
      full_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      full_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      full_q  <= full_nxt;
      ready_q <= !full_nxt && open_nxt;
    end
  end

  // Payload carries no reset; it is only observed while full_q is set.
  always_ff @(posedge clk) begin
    if (valid && ready_q)
      data_q <= din;
  end

  assign ready = ready_q;
  assign full  = full_q;
  assign dout  = data_q;

endmodule

// File: rtl/axil_write_ctrl.sv
// AXI4-Lite write-path control: joins AW and W beats, performs the word
// write to register memory and hands the response to the B-channel stage.
module axil_write_ctrl
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 64,
  localparam int STRB_WIDTH = strb_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [2:0]            AWPROT,
  input  logic                  WVALID,
  output logic                  WREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [STRB_WIDTH-1:0] WSTRB,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [STRB_WIDTH-1:0] mem_wstrb,
  input  logic                  mem_ready,
  output logic                  WRESPREADY,
  output logic [1:0]            WRESP,
  input  logic                  BRESPREADY
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam logic [IDX_W:0] NUM_REGS_EXT = (IDX_W + 1)'(NUM_REGS);

  wr_state_e                  state_q, state_nxt;
  logic [1:0]                 resp_q, resp_nxt;
  logic                       aw_full, w_full;
  logic                       open_nxt, clr_hold;
  logic [IDX_W-1:0]           aw_idx;
  logic [DATA_WIDTH-1:0]      w_data;
  logic [STRB_WIDTH-1:0]      w_strb;
  logic                       out_of_range;
  logic                       unused_ok;

  // Protection bits and the byte offset within a word have no effect.
  assign unused_ok = ^{AWPROT, AWADDR[1:0]};

  assign open_nxt = (state_nxt == ST_IDLE);
  assign clr_hold = (state_q == ST_WAIT_B) && BRESPREADY;

  axil_hold_reg #(.WIDTH(IDX_W)) u_aw_hold (
    .clk      (clk),
    .resetn   (resetn),
    .valid    (AWVALID),
    .din      (AWADDR[ADDR_WIDTH-1:2]),
    .open_nxt (open_nxt),
    .clr      (clr_hold),
    .ready    (AWREADY),
    .full     (aw_full),
    .dout     (aw_idx)
  );

  axil_hold_reg #(.WIDTH(DATA_WIDTH + STRB_WIDTH)) u_w_hold (
    .clk      (clk),
    .resetn   (resetn),
    .valid    (WVALID),
    .din      ({WDATA, WSTRB}),
    .open_nxt (open_nxt),
    .clr      (clr_hold),
    .ready    (WREADY),
    .full     (w_full),
    .dout     ({w_data, w_strb})
  );

  assign out_of_range = ({1'b0, aw_idx} >= NUM_REGS_EXT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      resp_q  <= RESP_OKAY;
    end else begin
      state_q <= state_nxt;
      resp_q  <= resp_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    resp_nxt  = resp_q;
    case (state_q)
      ST_IDLE: begin
        if (aw_full && w_full)
          state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        if (out_of_range) begin
          resp_nxt  = RESP_SLVERR;
          state_nxt = ST_RESP;
        end else if (w_strb == '0) begin
          resp_nxt  = RESP_OKAY;
          state_nxt = ST_RESP;
        end else begin
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (mem_ready) begin
          resp_nxt  = RESP_OKAY;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP:   state_nxt = ST_WAIT_B;
      ST_WAIT_B: begin
        if (BRESPREADY)
          state_nxt = ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Memory bus is forced to zero outside WRITE so idle outputs read as 0.
  always_comb begin
    mem_wen    = (state_q == ST_WRITE);
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wstrb  = '0;
    if (mem_wen) begin
      mem_addr  = aw_idx;
      mem_wdata = w_data;
      mem_wstrb = w_strb;
    end
    WRESPREADY = (state_q == ST_RESP);
    WRESP      = resp_q;
  end

endmodule

// File: tb/tb_axil_write_ctrl.sv
// Scoreboard bench for axil_write_ctrl: directed writes push expected memory
// beats and responses; a negedge monitor pops and compares them.
module tb_axil_write_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        AWVALID, AWREADY;
  logic [11:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        WVALID, WREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        mem_wen;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic        WRESPREADY;
  logic [1:0]  WRESP;
  logic        BRESPREADY;

  axil_write_ctrl #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_REGS(64)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .AWVALID    (AWVALID),
    .AWREADY    (AWREADY),
    .AWADDR     (AWADDR),
    .AWPROT     (AWPROT),
    .WVALID     (WVALID),
    .WREADY     (WREADY),
    .WDATA      (WDATA),
    .WSTRB      (WSTRB),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .WRESPREADY (WRESPREADY),
    .WRESP      (WRESP),
    .BRESPREADY (BRESPREADY)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc = 0;
  int wen_first = -1;
  int wen_cycles = 0;
  int resp_count = 0;
  int resp_cyc = 0;
  logic [45:0] exp_mem[$];
  logic [1:0]  exp_resp[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got event expected none/other", nm);
  endtask

  // Monitor: every mem_wen cycle must match the head entry; pop on acceptance.
  always @(negedge clk) begin
    if (resetn) begin
      if (mem_wen) begin
        wen_cycles++;
        if (wen_first < 0) wen_first = cyc;
        if (exp_mem.size() == 0) fail("mem_unexpected");
        else begin
          chk("mem_write", {mem_addr, mem_wdata, mem_wstrb}, exp_mem[0]);
          if (mem_ready) void'(exp_mem.pop_front());
        end
      end
      if (WRESPREADY) begin
        resp_count++;
        resp_cyc = cyc;
        if (exp_resp.size() == 0) fail("resp_unexpected");
        else chk("wresp", WRESP, exp_resp.pop_front());
      end
    end
  end

  task automatic start_txn();
    wen_first  = -1;
    wen_cycles = 0;
  endtask

  task automatic send_both(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    bit ok = 0;
    @(posedge clk); #1;
    AWVALID = 1; AWADDR = a; AWPROT = 3'b010;
    WVALID  = 1; WDATA  = d; WSTRB  = s;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (AWREADY && WREADY) begin ok = 1; break; end
    end
    if (!ok) fail("both_ready_timeout");
    @(posedge clk); #1;
    acc = cyc; AWVALID = 0; WVALID = 0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    bit ok = 0;
    @(posedge clk); #1;
    WVALID = 1; WDATA = d; WSTRB = s;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (WREADY) begin ok = 1; break; end
    end
    if (!ok) fail("wready_timeout");
    @(posedge clk); #1;
    WVALID = 0;
  endtask

  task automatic send_aw(input logic [11:0] a);
    bit ok = 0;
    @(posedge clk); #1;
    AWVALID = 1; AWADDR = a; AWPROT = 3'b000;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (AWREADY) begin ok = 1; break; end
    end
    if (!ok) fail("awready_timeout");
    @(posedge clk); #1;
    acc = cyc; AWVALID = 0;
  endtask

  task automatic wait_resp(input int start);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (resp_count > start) begin ok = 1; break; end
    end
    if (!ok) fail("resp_timeout");
  endtask

  task automatic b_pulse(input int delay);
    @(posedge clk); #1;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk("bwait_ready_low", {AWREADY, WREADY}, 2'b00);
      @(posedge clk); #1;
    end
    BRESPREADY = 1;
    @(negedge clk);
    chk("bpulse_ready_low", {AWREADY, WREADY}, 2'b00);
    @(posedge clk); #1;
    BRESPREADY = 0;
    @(negedge clk);
    chk("ready_back", {AWREADY, WREADY}, 2'b11);
  endtask

  task automatic wait_wen();
    bit ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (mem_wen) begin ok = 1; break; end
    end
    if (!ok) fail("wen_timeout");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int r0;
    resetn = 0; AWVALID = 0; AWADDR = '0; AWPROT = '0; WVALID = 0;
    WDATA = '0; WSTRB = '0; mem_ready = 1; BRESPREADY = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {AWREADY, WREADY, mem_wen, WRESPREADY, WRESP, mem_addr, mem_wdata, mem_wstrb}, 0);
    @(posedge clk); #1 resetn = 1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_reset", {AWREADY, WREADY}, 2'b11);

    // 1: same-cycle AW+W, idx 4
    start_txn(); r0 = resp_count;
    exp_mem.push_back({10'd4, 32'hDEADBEEF, 4'hF}); exp_resp.push_back(2'b00);
    send_both(12'h010, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    chk("t1_ready_drop", {AWREADY, WREADY}, 2'b00);
    wait_resp(r0);
    chk("t1_wen_latency", wen_first - acc, 2);
    chk("t1_resp_latency", resp_cyc - acc, 3);
    b_pulse(0);

    // 2: W first, AW three cycles later, idx 2
    start_txn(); r0 = resp_count;
    exp_mem.push_back({10'd2, 32'h12345678, 4'hF}); exp_resp.push_back(2'b00);
    send_w(32'h12345678, 4'hF);
    @(negedge clk);
    chk("t2_wready_low", WREADY, 1'b0);
    chk("t2_awready_high", AWREADY, 1'b1);
    repeat (2) @(posedge clk);
    chk("t2_no_wen_yet", wen_cycles, 0);
    send_aw(12'h008);
    wait_resp(r0);
    chk("t2_wen_latency", wen_first - acc, 2);
    b_pulse(0);
    repeat (3) @(negedge clk);
    chk("t2_one_resp", resp_count - r0, 1);

    // 3: idx 64 out of range -> SLVERR, no write
    start_txn(); r0 = resp_count;
    exp_resp.push_back(2'b10);
    send_both(12'h100, 32'hCAFEF00D, 4'hF);
    wait_resp(r0);
    chk("t3_no_wen", wen_cycles, 0);
    chk("t3_resp_latency", resp_cyc - acc, 2);
    b_pulse(0);

    // 4a: zero strobe -> OKAY, no write
    start_txn(); r0 = resp_count;
    exp_resp.push_back(2'b00);
    send_both(12'h020, 32'h87654321, 4'h0);
    wait_resp(r0);
    chk("t4_no_wen", wen_cycles, 0);
    chk("t4_resp_latency", resp_cyc - acc, 2);
    b_pulse(0);

    // 4b: partial strobe 0x5, idx 15
    start_txn(); r0 = resp_count;
    exp_mem.push_back({10'd15, 32'hA5A5A5A5, 4'h5}); exp_resp.push_back(2'b00);
    send_both(12'h03C, 32'hA5A5A5A5, 4'h5);
    wait_resp(r0);
    chk("t4b_wen_cycles", wen_cycles, 1);
    b_pulse(0);

    // 4c: unaligned address in last word (idx 63)
    start_txn(); r0 = resp_count;
    exp_mem.push_back({10'd63, 32'h0BADF00D, 4'hC}); exp_resp.push_back(2'b00);
    send_both(12'h0FE, 32'h0BADF00D, 4'hC);
    wait_resp(r0);
    chk("t4c_wen_cycles", wen_cycles, 1);
    b_pulse(0);

    // 5: mem_ready low 5 cycles, BRESPREADY delayed 4 cycles
    start_txn(); r0 = resp_count;
    mem_ready = 0;
    exp_mem.push_back({10'd7, 32'h55AA55AA, 4'hF}); exp_resp.push_back(2'b00);
    send_both(12'h01C, 32'h55AA55AA, 4'hF);
    wait_wen();
    repeat (4) @(negedge clk);
    @(posedge clk); #1 mem_ready = 1;
    wait_resp(r0);
    chk("t5_wen_cycles", wen_cycles, 6);
    b_pulse(4);

    // 6: reset during WRITE, then a clean write
    start_txn(); r0 = resp_count;
    mem_ready = 0;
    exp_mem.push_back({10'd8, 32'h11112222, 4'hF});
    send_both(12'h020, 32'h11112222, 4'hF);
    wait_wen();
    #1 resetn = 0;
    exp_mem.delete(); exp_resp.delete();
    #1 chk("t6_reset_outputs", {mem_wen, AWREADY, WREADY, WRESPREADY}, 4'b0000);
    repeat (3) @(posedge clk);
    #1 resetn = 1; mem_ready = 1;
    repeat (3) @(negedge clk);
    chk("t6_no_resp", resp_count - r0, 0);
    start_txn(); r0 = resp_count;
    exp_mem.push_back({10'd9, 32'h33334444, 4'h3}); exp_resp.push_back(2'b00);
    send_both(12'h024, 32'h33334444, 4'h3);
    wait_resp(r0);
    chk("t6_resp_latency", resp_cyc - acc, 3);
    b_pulse(0);

    repeat (3) @(negedge clk);
    chk("exp_mem_drained", exp_mem.size(), 0);
    chk("exp_resp_drained", exp_resp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
